// File: rtl/fft_pkg.sv
// fft_pkg: shared sizing constants, FSM state encodings and the twiddle-base helper
//   for the FFT stage sequencer.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package fft_pkg;

  localparam int N_POINTS = 32;
  localparam int N_MACS   = 4;

  localparam int STAGES = $clog2(N_POINTS);
  localparam int PASSES = N_POINTS / (2 * N_MACS);
  localparam int SEL_W  = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int STG_W  = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam int TW_W   = $clog2(N_POINTS / 2);

  // FSM state encodings
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  // Twiddle exponent base for a pass:
  //   ((sel*N_MACS) mod 2^stg) << (STAGES-1-stg), truncated to TW_W bits.
  // The mod is a mask because 2^stg is a power of two.
  function automatic logic [TW_W-1:0] tw_index(input logic [SEL_W-1:0] sel,
                                                input logic [STG_W-1:0] stg);
    logic [31:0] base;
    logic [31:0] mask;
    base = 32'(sel) * 32'(N_MACS);
    mask = (32'd1 << stg) - 32'd1;
    return TW_W'((base & mask) << (STAGES - 1 - int'(stg)));
  endfunction

endpackage

// File: rtl/fft_lat_pipe.sv
// fft_lat_pipe: LAT-deep shift register of {valid, sel}, aligning write-back with the MAC pipe.
//   Ports: clk/reset; valid/sel in; valid_d/sel_d out. LAT=0 passes straight through.
// Latency: LAT cycles. Backpressure: none, it always advances (also while the sequencer is held).
module fft_lat_pipe #(
  parameter int LAT = 1,
  parameter int W   = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid,
  input  logic [W-1:0] sel,
  output logic         valid_d,
  output logic [W-1:0] sel_d
);

  // At least one register exists so the port list is used for every LAT;
  // for LAT=0 the output mux bypasses it.
  localparam int D = (LAT == 0) ? 1 : LAT;

  logic [D-1:0] vld_sr;
  logic [W-1:0] sel_sr [D];

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_sr <= '0;
      for (int i = 0; i < D; i++) sel_sr[i] <= '0;
    end else begin
      vld_sr[0] <= valid;
      sel_sr[0] <= sel;
      for (int i = 1; i < D; i++) begin
        vld_sr[i] <= vld_sr[i-1];
        sel_sr[i] <= sel_sr[i-1];
      end
    end
  end

  assign valid_d = (LAT == 0) ? valid : vld_sr[D-1];
  assign sel_d   = (LAT == 0) ? sel   : sel_sr[D-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: steps the radix-2 MAC array through PASSES passes for each of STAGES stages.
//   Ports: start/hold in; busy/done, mac_sel/stage/issue, rd_bank/wr_bank, tw_base, wr_en/wr_sel out.
// Latency: start -> busy next cycle; write-back = issue + MAC_LAT. Backpressure: hold stalls pass issue in RUN only.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int MAC_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             hold,
  output logic             busy,
  output logic             done,
  output logic [SEL_W-1:0] mac_sel,
  output logic [STG_W-1:0] stage,
  output logic             issue,
  output logic             rd_bank,
  output logic             wr_bank,
  output logic [TW_W-1:0]  tw_base,
  output logic             wr_en,
  output logic [SEL_W-1:0] wr_sel
);

  logic [1:0] state;
  logic [2:0] drain_cnt;
  logic       last_pass;
  logic       last_stage;
  logic       advance;

  assign last_pass  = (mac_sel == SEL_W'(PASSES - 1));
  assign last_stage = (stage == STG_W'(STAGES - 1));

  assign issue   = (state == RUN) && !hold;
  assign busy    = (state == RUN) || (state == DRAIN);
  assign done    = (state == DONE);
  assign rd_bank = stage[0];
  assign wr_bank = ~stage[0];
  assign tw_base = tw_index(mac_sel, stage);

  // Stage boundary: final pass issued with no MAC pipe to drain, or the drain
  // counter has run out. Resolved in the same cycle, no separate NEXT state.
  always_comb begin
    advance = 1'b0;
    if (state == RUN && issue && last_pass && MAC_LAT == 0) advance = 1'b1;
    if (state == DRAIN && drain_cnt == 3'd0)                advance = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mac_sel   <= '0;
      stage     <= '0;
      drain_cnt <= '0;
    end else if (advance) begin
      mac_sel <= '0;
      if (last_stage) begin
        state <= DONE;
      end else begin
        stage <= stage + STG_W'(1);
        state <= RUN;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            stage   <= '0;
            mac_sel <= '0;
          end
        end
        RUN: begin
          if (issue) begin
            if (last_pass) begin
              // mac_sel holds at PASSES-1 through the drain; it only wraps at the boundary.
              state     <= DRAIN;
              drain_cnt <= 3'(MAC_LAT - 1);
            end else begin
              mac_sel <= mac_sel + SEL_W'(1);
            end
          end
        end
        DRAIN: drain_cnt <= drain_cnt - 3'd1;
        default: begin
          state <= IDLE;
          stage <= '0;
        end
      endcase
    end
  end

  fft_lat_pipe #(
    .LAT (MAC_LAT),
    .W   (SEL_W)
  ) u_lat_pipe (
    .clk     (clk),
    .reset   (reset),
    .valid   (issue),
    .sel     (mac_sel),
    .valid_d (wr_en),
    .sel_d   (wr_sel)
  );

endmodule

// File: doc/fft_stage_sequencer.md
Name: fft_stage_sequencer

Overview:
- Sequences the time-multiplexed radix-2 butterfly MAC array across all log2(N) stages of an N-point FFT.
- Per stage, it drives the MAC pass select (mac_sel) through N/(2*N_MACS) passes.
- It also generates the twiddle base index, ping-pong bank selects and the write-back strobes aligned to MAC latency.
- Sits between the top-level FFT control (start/done) and the per-stage MAC mux/demux datapath.

Parameters:
N_POINTS, 32, FFT size (power of 2, >= 4)
N_MACS, 4, butterfly MAC units working in parallel per pass
MAC_LAT, 1, MAC pipeline latency in cycles (0..7); 0 = combinational MAC
Derived constants (package): STAGES = log2(N_POINTS) = 5; PASSES = N_POINTS/(2*N_MACS) = 4; SEL_W = log2(PASSES) = 2; STG_W = 3; TW_W = log2(N_POINTS/2) = 4

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; all state and outputs cleared at the clock edge where reset=1
start  input  1  begin one FFT; sampled only in IDLE
hold  input  1  stall: freezes pass issue while high
busy  output  1  high from the cycle after accepted start through the last drain cycle
done  output  1  one-cycle pulse after the final stage write-back
mac_sel  output  SEL_W  pass index driven to MAC input mux/output demux
stage  output  STG_W  current stage 0..STAGES-1
issue  output  1  a valid pass is presented to the MACs this cycle
rd_bank  output  1  ping-pong bank read this stage; equals stage[0]
wr_bank  output  1  ping-pong bank written this stage; equals ~stage[0]
tw_base  output  TW_W  twiddle exponent base for pass: ((mac_sel*N_MACS) mod 2^stage) << (STAGES-1-stage)
wr_en  output  1  write-back strobe: issue delayed by MAC_LAT cycles
wr_sel  output  SEL_W  mac_sel delayed by MAC_LAT cycles; selects demux slot written

Behaviour:
- Reset values: state=IDLE; busy=0, done=0, issue=0, wr_en=0; mac_sel=0, stage=0, wr_sel=0, tw_base=0; rd_bank=0, wr_bank=1. The delay line is cleared. Reset mid-operation aborts immediately with no done pulse.
- States:
  - IDLE: start=1 -> RUN with stage=0, mac_sel=0.
  - RUN: issue = ~hold. On an issuing cycle, mac_sel increments. When mac_sel=PASSES-1 issues: if MAC_LAT=0, go to NEXT; else go to DRAIN and load drain counter = MAC_LAT-1.
  - DRAIN: issue=0. Counter decrements every cycle regardless of hold; at 0 -> NEXT.
  - NEXT (combinational decision, no extra cycle): if stage=STAGES-1 -> DONE; else stage+1, mac_sel=0, -> RUN.
  - DONE: done=1 and busy=0 for one cycle -> IDLE.
- busy=1 in RUN and DRAIN only.
- Cycle count with hold=0: busy lasts STAGES*(PASSES+MAC_LAT) cycles (default 25); done is in the next cycle.
- The delay line (MAC_LAT stages of {issue, mac_sel}) always advances, including during hold. In-flight writes complete before a stage changes, because DRAIN covers MAC_LAT.
- hold=1 in RUN: mac_sel and stage are frozen and issue=0. It has no effect in IDLE, DRAIN or DONE.
- start while not IDLE is ignored. start in the DONE cycle is ignored; a new start is accepted from IDLE the next cycle.
- mac_sel wraps PASSES-1 -> 0 only at a stage boundary. It is never left non-zero in IDLE.
- tw_base is combinational from stage/mac_sel, computed modulo 2^TW_W.

Decomposition:
- Package fft_pkg: N_POINTS, N_MACS, STAGES, PASSES, SEL_W, STG_W, TW_W, and a state enum {IDLE, RUN, DRAIN, DONE}.
- One sub-module: fft_lat_pipe, a parameterized MAC_LAT-deep shift register of {valid, sel} with synchronous reset. For MAC_LAT=0 it is a pass-through.

Test Plan:
- Reset then idle (reset=1 for 2 cycles, start=0) -> all outputs at reset values; busy=0 for 10 cycles.
- Nominal run (MAC_LAT=1, start pulse at cycle 0):
  - busy=1 during cycles 1..25; done=1 at cycle 26 only.
  - mac_sel sequence 0,1,2,3,hold-drain per stage; stage 0..4.
  - wr_en follows issue by 1 cycle with wr_sel = previous mac_sel.
  - rd_bank toggles 0,1,0,1,0.
- Twiddle check:
  - stage 0 -> tw_base=0 for all passes.
  - stage 2, mac_sel=1 -> tw_base=((4 mod 4)<<2)=0.
  - stage 4, mac_sel=3 -> tw_base=(12 mod 16)<<0=12.
  - stage 3, mac_sel=1 -> (4 mod 8)<<1=8.
- Hold: hold=1 for 3 cycles at stage 1, mac_sel=2 -> mac_sel stays 2, issue=0, the pending wr_en still fires once; done is delayed by exactly 3 cycles (cycle 29).
- Start while busy (pulse at cycle 10) -> ignored, done still at 26. Back-to-back start at cycle 27 -> second done at cycle 53.
- Reset mid-run (reset at cycle 12) -> next cycle state=IDLE, busy=0, wr_en=0, no done. MAC_LAT=0 build: busy cycles 1..20, done at 21, wr_en==issue.
